huffman_merge_ctrl: RTL and testbench

Sequencer for the array of node storage units during Huffman tree construction. It repeatedly scans all units for the two lowest-weight valid nodes, cleans one unit, writes the merged parent node into the other, and emits a (left, right, parent, weight) record to the code-length stage. It stops when one valid node, the root, remains. It sits between the leaf-load logic, the node-unit array and the tree/code-length builder.

---
 rtl/huffman_merge_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_huffman_merge_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_merge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : huffman_merge_ctrl
// Purpose  : Huffman tree-build sequencer. Repeatedly scans the node-unit
//            array for the two lowest-weight valid nodes. It cleans the unit
//            holding the second-lowest node and writes the merged parent into
//            the unit holding the lowest. It then emits a merge record. The
//            build ends when a single root node remains.
// Ports    : clk, rstN          - clock, asynchronous active-low reset
//            start              - begin a build (honoured in IDLE/DONE only)
//            node_bus           - all unit outputs, unit i at [36*i +: 36]
//            node_in_o/node_wr_o- merged frame and one-hot unit write strobe
//            clean_o/clean_en_o - unit number to clean and its strobe
//            pair_*             - merge record with valid/ready handshake
//            busy/done/root_id/empty_err - build status
// Revision : 1.0 - initial release
// ============================================================================
module huffman_merge_ctrl #(
    parameter int         N           = 16,
    parameter logic [7:0] PARENT_BASE = 8'd16
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            start,
    input  logic [N*36-1:0] node_bus,
    output logic [35:0]     node_in_o,
    output logic [N-1:0]    node_wr_o,
    output logic [7:0]      clean_o,
    output logic            clean_en_o,
    output logic            pair_valid,
    input  logic            pair_ready,
    output logic [7:0]      pair_left,
    output logic [7:0]      pair_right,
    output logic [7:0]      pair_parent,
    output logic [27:0]     pair_weight,
    output logic            busy,
    output logic            done,
    output logic [7:0]      root_id,
    output logic            empty_err
);

    localparam int            IW      = $clog2(N);
    localparam logic [35:0]   c_EMPTY = 36'hF_FFFF_FFFF;
    localparam logic [27:0]   c_WINIT = 28'hFFF_FFFF;
    localparam logic [27:0]   c_WSAT  = 28'hFFF_FFFE;
    localparam logic [IW-1:0] c_LAST  = IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_EVAL  = 3'd2,
        S_CLEAN = 3'd3,
        S_WRITE = 3'd4,
        S_EMIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [27:0]   r_min1_w;
    logic [27:0]   r_min2_w;
    logic [7:0]    r_min1_id;
    logic [7:0]    r_min2_id;
    logic [IW-1:0] r_min1_ux;
    logic [IW-1:0] r_min2_ux;
    logic [1:0]    r_cnt;
    logic [7:0]    r_parent;

    logic [35:0]   w_unit [N];
    logic [35:0]   w_cur;
    logic          w_cur_valid;
    logic [28:0]   w_sum29;
    logic [27:0]   w_sum;
    logic [N-1:0]  w_wr_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unit
            assign w_unit[gi] = node_bus[36*gi +: 36];
        end
    endgenerate

    assign w_cur       = w_unit[r_idx];
    assign w_cur_valid = (w_cur != c_EMPTY);

    // Both children are valid whenever the sum is used, so the 29-bit sum
    // can only exceed the largest legal weight, never wrap unnoticed.
    assign w_sum29     = {1'b0, r_min1_w} + {1'b0, r_min2_w};
    assign w_sum       = (w_sum29 > {1'b0, c_WSAT}) ? c_WSAT : w_sum29[27:0];
    assign w_wr_onehot = {{(N-1){1'b0}}, 1'b1} << r_min1_ux;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_min1_w    <= '0;
            r_min2_w    <= '0;
            r_min1_id   <= '0;
            r_min2_id   <= '0;
            r_min1_ux   <= '0;
            r_min2_ux   <= '0;
            r_cnt       <= '0;
            r_parent    <= '0;
            node_in_o   <= '0;
            node_wr_o   <= '0;
            clean_o     <= '0;
            clean_en_o  <= 1'b0;
            pair_valid  <= 1'b0;
            pair_left   <= '0;
            pair_right  <= '0;
            pair_parent <= '0;
            pair_weight <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            root_id     <= '0;
            empty_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state   <= S_SCAN;
                        r_idx     <= '0;
                        r_min1_w  <= c_WINIT;
                        r_min2_w  <= c_WINIT;
                        r_cnt     <= '0;
                        r_parent  <= PARENT_BASE;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        root_id   <= '0;
                        empty_err <= 1'b0;
                    end
                end
                S_SCAN: begin
                    // Strict compares: on a weight tie the earlier unit wins
                    // the lower slot.
                    if (w_cur_valid) begin
                        if (w_cur[35:8] < r_min1_w) begin
                            r_min2_w  <= r_min1_w;
                            r_min2_id <= r_min1_id;
                            r_min2_ux <= r_min1_ux;
                            r_min1_w  <= w_cur[35:8];
                            r_min1_id <= w_cur[7:0];
                            r_min1_ux <= r_idx;
                        end else if (w_cur[35:8] < r_min2_w) begin
                            r_min2_w  <= w_cur[35:8];
                            r_min2_id <= w_cur[7:0];
                            r_min2_ux <= r_idx;
                        end
                        if (r_cnt != 2'd2) begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                    if (r_idx == c_LAST) begin
                        r_state <= S_EVAL;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_EVAL: begin
                    case (r_cnt)
                        2'd0: begin
                            r_state   <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            empty_err <= 1'b1;
                            root_id   <= '0;
                        end
                        2'd1: begin
                            r_state   <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            empty_err <= 1'b0;
                            root_id   <= r_min1_id;
                        end
                        default: begin
                            r_state    <= S_CLEAN;
                            clean_en_o <= 1'b1;
                            clean_o    <= 8'(r_min2_ux);
                        end
                    endcase
                end
                S_CLEAN: begin
                    r_state    <= S_WRITE;
                    clean_en_o <= 1'b0;
                    node_wr_o  <= w_wr_onehot;
                    node_in_o  <= {w_sum, r_parent};
                end
                S_WRITE: begin
                    r_state     <= S_EMIT;
                    node_wr_o   <= '0;
                    node_in_o   <= '0;
                    pair_valid  <= 1'b1;
                    pair_left   <= r_min1_id;
                    pair_right  <= r_min2_id;
                    pair_parent <= r_parent;
                    pair_weight <= w_sum;
                end
                S_EMIT: begin
                    // The unit write has settled on node_bus by now, so the
                    // rescan can start right after the handshake.
                    if (pair_ready) begin
                        r_state    <= S_SCAN;
                        pair_valid <= 1'b0;
                        r_parent   <= r_parent + 8'd1;
                        r_idx      <= '0;
                        r_min1_w   <= c_WINIT;
                        r_min2_w   <= c_WINIT;
                        r_cnt      <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_huffman_merge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_huffman_merge_ctrl
// Purpose  : Self-checking bench for huffman_merge_ctrl with a behavioural
//            node-unit array and a reference model of the expected merges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_huffman_merge_ctrl;

    localparam int          N     = 4;
    localparam logic [7:0]  PB    = 8'd4;
    localparam logic [35:0] EMPTY = 36'hF_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rstN = 1'b0;
    logic            start = 1'b0;
    logic            pair_ready = 1'b1;
    logic [N*36-1:0] node_bus;
    logic [35:0]     node_in_o;
    logic [N-1:0]    node_wr_o;
    logic [7:0]      clean_o;
    logic            clean_en_o;
    logic            pair_valid;
    logic [7:0]      pair_left, pair_right, pair_parent;
    logic [27:0]     pair_weight;
    logic            busy, done, empty_err;
    logic [7:0]      root_id;

    always #5 clk = ~clk;

    huffman_merge_ctrl #(.N(N), .PARENT_BASE(PB)) dut (
        .clk(clk), .rstN(rstN), .start(start), .node_bus(node_bus),
        .node_in_o(node_in_o), .node_wr_o(node_wr_o), .clean_o(clean_o),
        .clean_en_o(clean_en_o), .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pair_left(pair_left), .pair_right(pair_right), .pair_parent(pair_parent),
        .pair_weight(pair_weight), .busy(busy), .done(done), .root_id(root_id),
        .empty_err(empty_err)
    );

    // Behavioural node-unit array
    logic [35:0] units   [N];
    logic [35:0] ld_vals [N];
    logic        ld_en = 1'b0;

    always @(posedge clk) begin
        if (ld_en) begin
            units <= ld_vals;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (clean_en_o && int'(clean_o) == i) units[i] <= EMPTY;
                if (node_wr_o[i]) units[i] <= node_in_o;
            end
        end
    end

    always_comb begin
        node_bus = '0;
        for (int i = 0; i < N; i++) node_bus[36*i +: 36] = units[i];
    end

    // Reference model: repeated "take the two lightest, ties to lower unit"
    typedef struct {
        logic [7:0]  l, r, p;
        logic [27:0] w;
        int          cln, wru;
    } rec_t;

    rec_t       exp_q [$];
    logic [7:0] exp_root;
    logic       exp_empty;

    task automatic build_model();
        logic [35:0] m [N];
        logic [7:0]  par;
        logic [28:0] s;
        int          a, b, cnt;
        rec_t        rc;
        m = ld_vals;
        par = PB;
        exp_q.delete();
        exp_root = '0;
        exp_empty = 1'b0;
        while (1) begin
            cnt = 0; a = -1; b = -1;
            for (int i = 0; i < N; i++) begin
                if (m[i] != EMPTY) begin
                    cnt++;
                    if (a < 0 || m[i][35:8] < m[a][35:8]) a = i;
                end
            end
            if (cnt < 2) begin
                exp_empty = (cnt == 0);
                exp_root  = (cnt == 1) ? m[a][7:0] : 8'd0;
                break;
            end
            for (int i = 0; i < N; i++) begin
                if (i != a && m[i] != EMPTY && (b < 0 || m[i][35:8] < m[b][35:8])) b = i;
            end
            s = {1'b0, m[a][35:8]} + {1'b0, m[b][35:8]};
            rc.l = m[a][7:0];
            rc.r = m[b][7:0];
            rc.p = par;
            rc.w = (s > 29'h0FFF_FFFE) ? 28'hFFF_FFFE : s[27:0];
            rc.cln = b;
            rc.wru = a;
            exp_q.push_back(rc);
            m[b] = EMPTY;
            m[a] = {rc.w, par};
            par = par + 8'd1;
        end
    endtask

    // Checking infrastructure
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected / did not occur", name);
    endtask

    // Monitor: per-cycle comparison against the model
    bit   chk_en = 1'b0;
    bit   build_done = 1'b0;
    int   rec_i = 0;
    int   since = 0;
    int   vcyc = 0;
    int   first_vcyc = 0;
    logic prev_valid = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            since++;
            if (clean_en_o && node_wr_o != '0) fail_now("strobe_overlap");
            if (pair_valid && (clean_en_o || node_wr_o != '0)) fail_now("strobe_in_emit");
            if (clean_en_o) begin
                if (rec_i < exp_q.size()) check("clean_unit", clean_o, exp_q[rec_i].cln);
                else fail_now("clean_unexpected");
            end
            if (node_wr_o != '0) begin
                if (rec_i < exp_q.size()) begin
                    logic [N-1:0] oh;
                    oh = 1;
                    oh = oh << exp_q[rec_i].wru;
                    check("write_strobe", node_wr_o, oh);
                    check("write_frame", node_in_o, {exp_q[rec_i].w, exp_q[rec_i].p});
                end else fail_now("write_unexpected");
            end
            if (pair_valid) begin
                if (!prev_valid) check("pair_latency", since, N + 4);
                check("busy_in_emit", busy, 1);
                if (rec_i < exp_q.size())
                    check("pair_record", {pair_left, pair_right, pair_parent, pair_weight},
                          {exp_q[rec_i].l, exp_q[rec_i].r, exp_q[rec_i].p, exp_q[rec_i].w});
                else fail_now("pair_unexpected");
                vcyc++;
                if (pair_ready) begin
                    if (rec_i == 0) first_vcyc = vcyc;
                    vcyc = 0;
                    rec_i++;
                    since = 0;
                end
            end
            if (done && !prev_done) begin
                check("done_latency", since, N + 2);
                check("done_root", root_id, exp_root);
                check("done_empty_err", empty_err, exp_empty);
                check("done_all_records", rec_i, exp_q.size());
                check("done_not_busy", busy, 0);
                build_done = 1'b1;
            end
            if (start && !busy) since = 0;
        end
        prev_valid = pair_valid;
        prev_done  = done;
    end

    // pair_ready driver
    int stall_cnt = 0;
    bit rnd_ready = 1'b0;

    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            pair_ready = 1'b0;
            if (pair_valid) stall_cnt--;
        end else begin
            pair_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic load_and_start(input logic [35:0] v [N]);
        @(posedge clk); #1;
        ld_vals = v;
        ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
        build_model();
        rec_i = 0;
        build_done = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 400 && !build_done; c++) @(posedge clk);
        if (!build_done) fail_now("build_timeout");
    endtask

    task automatic check_all_zero(input string name);
        check(name, {node_in_o, node_wr_o, clean_o, clean_en_o, pair_valid},
              '0);
        check(name, {pair_left, pair_right, pair_parent, pair_weight, busy, done, root_id, empty_err},
              '0);
    endtask

    logic [35:0] pv [N];
    logic [35:0] v  [N];
    logic [27:0] w;

    initial begin
        pv = '{{28'd5, 8'd0}, {28'd3, 8'd1}, {28'd3, 8'd2}, {28'd7, 8'd3}};
        for (int i = 0; i < N; i++) ld_vals[i] = EMPTY;
        ld_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        ld_en = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        chk_en = 1'b1;

        // Worked example, free-flowing handshake; model pinned to hand values
        load_and_start(pv);
        check("model_nrec", exp_q.size(), 3);
        if (exp_q.size() == 3) begin
            check("model_rec0", {exp_q[0].l, exp_q[0].r, exp_q[0].p, exp_q[0].w, 8'(exp_q[0].cln), 8'(exp_q[0].wru)},
                  {8'd1, 8'd2, 8'd4, 28'd6, 8'd2, 8'd1});
            check("model_rec1", {exp_q[1].l, exp_q[1].r, exp_q[1].p, exp_q[1].w, 8'(exp_q[1].cln), 8'(exp_q[1].wru)},
                  {8'd0, 8'd4, 8'd5, 28'd11, 8'd1, 8'd0});
            check("model_rec2", {exp_q[2].l, exp_q[2].r, exp_q[2].p, exp_q[2].w, 8'(exp_q[2].cln), 8'(exp_q[2].wru)},
                  {8'd3, 8'd5, 8'd6, 28'd18, 8'd0, 8'd3});
        end
        check("model_root", exp_root, 8'd6);
        wait_done();
        #1;
        check("example_root", root_id, 8'd6);

        // Same example with a 5-cycle stall on the first record
        stall_cnt = 5;
        load_and_start(pv);
        wait_done();
        check("stall_valid_cycles", first_vcyc, 6);

        // All units empty
        for (int i = 0; i < N; i++) v[i] = EMPTY;
        load_and_start(v);
        check("model_empty", exp_empty, 1);
        wait_done();
        #1;
        check("empty_err_set", empty_err, 1);

        // Single valid unit
        v[1] = {28'd9, 8'd2};
        load_and_start(v);
        check("model_single", {exp_q.size() == 0, exp_root}, {1'b1, 8'd2});
        wait_done();
        #1;
        check("single_root", root_id, 8'd2);

        // Saturating sum
        for (int i = 0; i < N; i++) v[i] = EMPTY;
        v[0] = {28'hFFF_FFF0, 8'd7};
        v[3] = {28'hFFF_FFF0, 8'd9};
        load_and_start(v);
        if (exp_q.size() > 0) check("model_sat", exp_q[0].w, 28'hFFF_FFFE);
        else fail_now("model_sat_missing");
        wait_done();

        // Reset while a record is waiting in EMIT, then rebuild
        stall_cnt = 1000;
        load_and_start(pv);
        for (int c = 0; c < 100 && !pair_valid; c++) @(negedge clk);
        if (!pair_valid) fail_now("emit_not_reached");
        chk_en = 1'b0;
        rstN = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        stall_cnt = 0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset_no_strobes");
        rstN = 1'b1;
        chk_en = 1'b1;
        load_and_start(pv);
        wait_done();

        // Randomized builds with random backpressure
        rnd_ready = 1'b1;
        repeat (30) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    v[i] = EMPTY;
                end else begin
                    if ($urandom_range(0, 4) == 0) w = 28'($urandom_range(0, 32'h0FFF_FFFE));
                    else w = 28'($urandom_range(0, 12));
                    v[i] = {w, 8'($urandom)};
                end
            end
            load_and_start(v);
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
